// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - two-requester arbiter in front of one shared streaming multiplier.
// Define MUL_ARBITER_RR_EN for round-robin grant on simultaneous requests; default is fixed priority to requester 0.
module mul_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_val,
    output logic               req0_rdy,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_val,
    output logic               req1_rdy,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               resp0_val,
    input  logic               resp0_rdy,
    output logic [2*WIDTH-1:0] resp0_data,
    output logic               resp1_val,
    input  logic               resp1_rdy,
    output logic [2*WIDTH-1:0] resp1_data,
    output logic               mul_istream_val,
    input  logic               mul_istream_rdy,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_ostream_val,
    output logic               mul_ostream_rdy,
    input  logic [2*WIDTH-1:0] mul_result,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_owner;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_result;

    logic w_gnt0;
    logic w_gnt1;
    logic w_idle;
    logic w_resp_done;

`ifdef MUL_ARBITER_RR_EN
    // Holds the requester served last; starts at 1 so requester 0 wins the first tie.
    logic r_last;
    assign w_gnt0 = req0_val && (!req1_val || r_last);
`else
    assign w_gnt0 = req0_val;
`endif
    assign w_gnt1 = req1_val && !w_gnt0;

    // Reset gates the grant so nothing handshakes while the arbiter is held in reset.
    assign w_idle   = rst && (r_state == IDLE);
    assign req0_rdy = w_idle && w_gnt0;
    assign req1_rdy = w_idle && w_gnt1;

    assign mul_istream_val = (r_state == ISSUE);
    assign mul_ostream_rdy = (r_state == WAIT);
    assign mul_a           = r_a;
    assign mul_b           = r_b;
    assign busy            = (r_state != IDLE);

    assign resp0_val  = (r_state == RESP) && !r_owner;
    assign resp1_val  = (r_state == RESP) && r_owner;
    assign resp0_data = r_result;
    assign resp1_data = r_result;

    assign w_resp_done = (resp0_val && resp0_rdy) || (resp1_val && resp1_rdy);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_owner  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
`ifdef MUL_ARBITER_RR_EN
            r_last   <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0_rdy || req1_rdy) begin
                        r_owner <= w_gnt1;
                        r_a     <= w_gnt1 ? req1_a : req0_a;
                        r_b     <= w_gnt1 ? req1_b : req0_b;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mul_istream_rdy) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mul_ostream_val) begin
                        r_result <= mul_result;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    if (w_resp_done) begin
                        r_state <= IDLE;
`ifdef MUL_ARBITER_RR_EN
                        r_last  <= r_owner;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - directed scoreboard bench for mul_arbiter with a behavioural multiplier.
module tb_mul_arbiter;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           req0_val, req1_val;
    logic           req0_rdy, req1_rdy;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           resp0_val, resp1_val;
    logic           resp0_rdy, resp1_rdy;
    logic [2*W-1:0] resp0_data, resp1_data;
    logic           mul_istream_val, mul_istream_rdy;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_ostream_val, mul_ostream_rdy;
    logic [2*W-1:0] mul_result;
    logic           busy;

    mul_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_a(req0_a), .req0_b(req0_b),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_data(resp0_data),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_data(resp1_data),
        .mul_istream_val(mul_istream_val), .mul_istream_rdy(mul_istream_rdy),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_ostream_val(mul_ostream_val), .mul_ostream_rdy(mul_ostream_rdy),
        .mul_result(mul_result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared multiplier: accepts operands, waits m_lat cycles, then offers the product.
    int             m_lat;
    int             m_cnt;
    logic           m_busy;
    logic [2*W-1:0] m_res;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy          <= 1'b0;
            m_cnt           <= 0;
            m_res           <= '0;
            mul_ostream_val <= 1'b0;
            mul_result      <= '0;
        end else begin
            if (mul_istream_val && mul_istream_rdy) begin
                m_res  <= {32'b0, mul_a} * {32'b0, mul_b};
                m_cnt  <= m_lat;
                m_busy <= 1'b1;
            end else if (m_busy && !mul_ostream_val) begin
                if (m_cnt == 0) begin
                    mul_ostream_val <= 1'b1;
                    mul_result      <= m_res;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (mul_ostream_val && mul_ostream_rdy) begin
                mul_ostream_val <= 1'b0;
                m_busy          <= 1'b0;
            end
        end
    end

    typedef struct {
        int             id;
        logic [2*W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with request lines already driven; returns at a negedge after the handshake.
    task automatic arb_round(input int exp_id);
        bit   done;
        int   winner;
        exp_t e;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            #1;
            if (req0_rdy || req1_rdy) begin
                check("rdy_onehot", 64'(req0_rdy & req1_rdy), 64'd0);
                winner = req1_rdy ? 1 : 0;
                check("grant_id", 64'(winner), 64'(exp_id));
                e.id   = winner;
                e.data = winner ? {32'b0, req1_a} * {32'b0, req1_b} : {32'b0, req0_a} * {32'b0, req0_b};
                sb.push_back(e);
                @(posedge clk);
                @(negedge clk);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("grant_timeout", 64'(req0_rdy | req1_rdy), 64'd1);
    endtask

    task automatic get_resp();
        bit   done;
        exp_t e;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (resp0_val || resp1_val) begin
                check("resp_onehot", 64'(resp0_val & resp1_val), 64'd0);
                if (sb.size() == 0) begin
                    check("unexpected_resp", 64'(resp0_val | resp1_val), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_id", 64'(resp1_val), 64'(e.id));
                    check("resp_data", resp1_val ? resp1_data : resp0_data, e.data);
                end
                @(posedge clk);
                @(negedge clk);
                done = 1;
            end else begin
                check("busy_in_flight", 64'(busy), 64'd1);
                @(negedge clk);
            end
        end
        if (!done) check("resp_timeout", 64'(resp0_val | resp1_val), 64'd1);
    endtask

    initial begin
        bit seen;
        rst = 1'b0;
        req0_val = 1'b1; req1_val = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        mul_istream_rdy = 1'b1;
        m_lat = 2;

        // Reset state, with a request pending to prove rdy is gated.
        repeat (3) @(negedge clk);
        check("rst_req0_rdy", 64'(req0_rdy), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mul_ival", 64'(mul_istream_val), 64'd0);
        check("rst_mul_ordy", 64'(mul_ostream_rdy), 64'd0);
        check("rst_resp_val", 64'({resp0_val, resp1_val}), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        req0_val = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Single request 3 x 5.
        req0_a = 32'd3; req0_b = 32'd5; req0_val = 1'b1;
        arb_round(0);
        req0_val = 1'b0;
        check("single_busy", 64'(busy), 64'd1);
        check("single_mul_a", 64'(mul_a), 64'd3);
        check("single_mul_b", 64'(mul_b), 64'd5);
        check("single_resp1_val", 64'(resp1_val), 64'd0);
        get_resp();
        check("single_idle", 64'(busy), 64'd0);

        // Simultaneous requests right after reset.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req0_a = 32'd7; req0_b = 32'd9; req1_a = 32'd2; req1_b = 32'd4;
        req0_val = 1'b1; req1_val = 1'b1;
        arb_round(0);
        get_resp();
`ifdef MUL_ARBITER_RR_EN
        arb_round(1);
`else
        arb_round(0);
`endif
        get_resp();
        req0_val = 1'b0;
        arb_round(1);
        req1_val = 1'b0;
        get_resp();

        // Back-pressure on resp1 with the all-ones square, req0 waiting meanwhile.
        resp1_rdy = 1'b0;
        req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF; req1_val = 1'b1;
        arb_round(1);
        req1_val = 1'b0;
        req0_a = 32'd1; req0_b = 32'd1; req0_val = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (resp1_val) seen = 1;
            else @(negedge clk);
        end
        check("bp_resp_seen", 64'(resp1_val), 64'd1);
        for (int i = 0; i < 20; i++) begin
            check("bp_resp1_val", 64'(resp1_val), 64'd1);
            check("bp_resp1_data", resp1_data, 64'hFFFF_FFFE_0000_0001);
            check("bp_no_grant", 64'({req0_rdy, req1_rdy}), 64'd0);
            @(negedge clk);
        end
        resp1_rdy = 1'b1;
        get_resp();
        arb_round(0);
        req0_val = 1'b0;
        get_resp();

        // Multiplier input stall: operands must hold, no grant to a waiting requester.
        mul_istream_rdy = 1'b0;
        req0_a = 32'd11; req0_b = 32'd13; req0_val = 1'b1;
        arb_round(0);
        req0_val = 1'b0;
        req1_a = 32'd2; req1_b = 32'd2; req1_val = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stall_ival", 64'(mul_istream_val), 64'd1);
            check("stall_mul_a", 64'(mul_a), 64'd11);
            check("stall_mul_b", 64'(mul_b), 64'd13);
            check("stall_no_grant", 64'({req0_rdy, req1_rdy}), 64'd0);
            @(negedge clk);
        end
        mul_istream_rdy = 1'b1;
        get_resp();
        arb_round(1);
        req1_val = 1'b0;
        get_resp();

        // Reset while waiting on the multiplier aborts the transaction.
        m_lat = 10;
        req0_a = 32'd6; req0_b = 32'd7; req0_val = 1'b1;
        arb_round(0);
        req0_val = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (mul_ostream_rdy) seen = 1;
            else @(negedge clk);
        end
        check("abort_in_wait", 64'(mul_ostream_rdy), 64'd1);
        rst = 1'b0;
        #1;
        sb.delete();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ordy", 64'(mul_ostream_rdy), 64'd0);
        check("abort_ival", 64'(mul_istream_val), 64'd0);
        check("abort_mul_a", 64'(mul_a), 64'd0);
        check("abort_resp_val", 64'({resp0_val, resp1_val}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        m_lat = 2;
        for (int i = 0; i < 20; i++) begin
            check("post_abort_quiet", 64'({resp0_val, resp1_val, busy}), 64'd0);
            @(negedge clk);
        end
        req0_a = 32'd4; req0_b = 32'd5; req0_val = 1'b1;
        arb_round(0);
        req0_val = 1'b0;
        get_resp();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand width; result width is 2*WIDTH.
REQ-002 The module SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 The module SHALL have ports req0_val / req1_val, input, 1 each: requester N presents operands.
REQ-005 The module SHALL have ports req0_rdy / req1_rdy, output, 1 each: arbiter accepts requester N this cycle.
REQ-006 The module SHALL have ports req0_a, req0_b, req1_a, req1_b, input, WIDTH each: operands per requester.
REQ-007 The module SHALL have ports resp0_val / resp1_val, output, 1 each: product valid for requester N.
REQ-008 The module SHALL have ports resp0_rdy / resp1_rdy, input, 1 each: requester N takes product.
REQ-009 The module SHALL have ports resp0_data / resp1_data, output, 2*WIDTH each: product to requester N.
REQ-010 The module SHALL have port mul_istream_val, output, 1: operands offered to shared multiplier.
REQ-011 The module SHALL have port mul_istream_rdy, input, 1: multiplier accepts operands.
REQ-012 The module SHALL have ports mul_a / mul_b, output, WIDTH each: operands to multiplier.
REQ-013 The module SHALL have port mul_ostream_val, input, 1: multiplier result valid.
REQ-014 The module SHALL have port mul_ostream_rdy, output, 1: arbiter takes multiplier result.
REQ-015 The module SHALL have port mul_result, input, 2*WIDTH: multiplier product.
REQ-016 The module SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; IDLE->ISSUE on request handshake, ISSUE->WAIT on mul_istream_val&mul_istream_rdy, WAIT->RESP on mul_ostream_val&mul_ostream_rdy, RESP->IDLE on resp handshake of owner.
REQ-018 IDLE: reqN_rdy SHALL be combinationally high only for the granted requester among those with reqN_val=1; at most one reqN_rdy high per cycle; both 0 outside IDLE.
REQ-019 On request handshake, operands SHALL be registered and owner ID stored; mul_a/mul_b SHALL hold these registered values, stable ISSUE through RESP.
REQ-020 ISSUE: mul_istream_val SHALL be 1 until mul_istream_rdy; mul_istream_val=0 in all other states.
REQ-021 WAIT: mul_ostream_rdy SHALL be 1; mul_result registered on handshake; mul_ostream_val outside WAIT SHALL be ignored (mul_ostream_rdy=0).
REQ-022 RESP: only owner's respN_val SHALL be 1; respN_data SHALL hold registered product, stable until respN_rdy; non-owner resp_val=0.
REQ-023 Throughput: minimum 4 cycles per transaction plus multiplier latency; no pipelining, one transaction in flight.
REQ-024 Last-served pointer SHALL update to owner on RESP->IDLE; single request in IDLE SHALL be granted regardless of pointer.
REQ-025 Requests arriving in non-IDLE states SHALL wait (rdy=0); requester operands need not be held after handshake.
REQ-026 Back-pressure on resp (respN_rdy=0) SHALL stall in RESP indefinitely with no data loss.

Reset
REQ-027 rst=0 SHALL asynchronously force state IDLE, last-served pointer to 1, operand/result/owner registers to 0, all val/rdy outputs and busy to 0.
REQ-028 Reset mid-transaction SHALL abort it; no response issued afterwards; the multiplier shares rst and is reset together.

Configuration
REQ-029 With MUL_ARBITER_RR_EN defined, simultaneous requests SHALL be granted to the requester not last served (round-robin).
REQ-030 Without MUL_ARBITER_RR_EN, simultaneous requests SHALL always be granted to requester 0 (fixed priority); pointer register SHALL not be implemented.

Verification
REQ-031 Single request: req0 a=3,b=5 -> resp0_val with resp0_data=15, resp1_val stays 0, busy high from ISSUE to RESP.
REQ-032 Simultaneous after reset: req0 (7x9), req1 (2x4) held -> RR_EN: req0 served first (63), then req1 (8); without RR_EN: req0 always wins while it keeps requesting.
REQ-033 Back-pressure: resp1_rdy=0 for 20 cycles -> resp1_val and resp1_data=0xFFFFFFFE00000001 (0xFFFFFFFF squared) held stable, no new grant.
REQ-034 Multiplier stall: mul_istream_rdy=0 for 10 cycles -> mul_istream_val held with stable mul_a/mul_b, reqN_rdy=0.
REQ-035 Reset mid-WAIT: rst=0 while in WAIT -> all outputs 0 immediately; after release, no resp_val until a new request.
